// File: rtl/mc14500_pkg.sv
// ============================================================================
// Module   : mc14500_pkg
// Purpose  : Opcodes and sequencer state encodings shared by the LU,
//            the instruction sequencer and the bench.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package mc14500_pkg;

    localparam logic [3:0] OP_NOPO = 4'h0;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_RTN  = 4'hD;
    localparam logic [3:0] OP_SKZ  = 4'hE;
    localparam logic [3:0] OP_NOPF = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_JTGT  = 2'd2,
        ST_JSKIP = 2'd3
    } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/seq_return_stack.sv
// ============================================================================
// Module   : seq_return_stack
// Purpose  : Circular return-address stack. A push while full overwrites
//            the oldest entry; sticky overflow/underflow flags.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_return_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_addr,
    output logic [WIDTH-1:0] pop_addr,
    output logic             empty,
    output logic             ovf,
    output logic             unf
);

    localparam int c_ptr_w = $clog2(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_top;
    logic [c_ptr_w:0]   r_count;
    logic               r_ovf;
    logic               r_unf;
    logic               w_full;
    logic [c_ptr_w-1:0] w_top_idx;

    // r_top is the next free slot; the power-of-two depth makes wrap free.
    assign w_top_idx = r_top - 1'b1;
    assign w_full    = (r_count == (c_ptr_w + 1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign pop_addr  = r_mem[w_top_idx];
    assign ovf       = r_ovf;
    assign unf       = r_unf;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_top   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else if (push) begin
            r_top <= r_top + 1'b1;
            if (w_full) r_ovf   <= 1'b1;
            else        r_count <= r_count + 1'b1;
        end else if (pop) begin
            if (empty) begin
                r_unf <= 1'b1;
            end else begin
                r_top   <= w_top_idx;
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) r_mem[r_top] <= push_addr;
    end

endmodule

`default_nettype wire

// File: rtl/mc14500_sequencer.sv
// ============================================================================
// Module   : mc14500_sequencer
// Purpose  : PC/fetch/issue sequencer for the MC14500 LU with local JMP,
//            RTN and SKZ. Define MC14500_RTN_STACK_EN for the return stack.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mc14500_sequencer
    import mc14500_pkg::*;
#(
    parameter int ADDR_W      = 7,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    input  logic              lu_result,
    output logic [3:0]        lu_instruction,
    output logic              io_chip,
    output logic [2:0]        io_port,
    output logic              instr_valid,
    output logic              stk_ovf,
    output logic              stk_unf
);

    seq_state_t        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [3:0]        r_op;
    logic              r_chip;
    logic [2:0]        r_port;
    logic              r_valid;

    logic [3:0]        w_rom_op;
    logic [ADDR_W-1:0] w_pc_inc;
    logic              w_is_rtn;
    logic              w_suppress;
    logic [ADDR_W-1:0] w_skip_pc;
    logic              w_jskip_ok;

    assign w_rom_op   = rom_data[7:4];
    assign w_pc_inc   = r_pc + 1'b1;
    assign w_is_rtn   = (r_op == OP_RTN);
    // Decision is made on the word currently on lu_instruction.
    assign w_suppress = (r_state == ST_RUN) && run &&
                        (w_is_rtn || ((r_op == OP_SKZ) && !lu_result));

`ifdef MC14500_RTN_STACK_EN
    logic              w_push;
    logic              w_pop;
    logic              w_stk_empty;
    logic [ADDR_W-1:0] w_pop_addr;

    assign w_push     = (r_state == ST_JTGT) && run;
    assign w_pop      = w_suppress && w_is_rtn;
    assign w_skip_pc  = (w_pop && !w_stk_empty) ? w_pop_addr : w_pc_inc;
    assign w_jskip_ok = !w_is_rtn;

    seq_return_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (ADDR_W)
    ) u_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .pop       (w_pop),
        .push_addr (w_pc_inc),
        .pop_addr  (w_pop_addr),
        .empty     (w_stk_empty),
        .ovf       (stk_ovf),
        .unf       (stk_unf)
    );
`else
    assign w_skip_pc  = w_pc_inc;
    assign w_jskip_ok = 1'b1;
    assign stk_ovf    = 1'b0;
    assign stk_unf    = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_pc    <= '0;
            r_op    <= OP_NOPO;
            r_chip  <= 1'b0;
            r_port  <= 3'd0;
            r_valid <= 1'b0;
        end else begin
            // Injected NOPO is the default issue; only a real fetch overrides it.
            r_op    <= OP_NOPO;
            r_chip  <= 1'b0;
            r_port  <= 3'd0;
            r_valid <= 1'b0;
            if (r_state == ST_IDLE) begin
                if (run) r_state <= ST_RUN;
            end else if (run) begin
                case (r_state)
                    ST_RUN: begin
                        if (w_suppress) begin
                            r_pc <= w_skip_pc;
                            if (w_rom_op == OP_JMP && w_jskip_ok) r_state <= ST_JSKIP;
                        end else begin
                            r_op    <= w_rom_op;
                            r_chip  <= rom_data[3];
                            r_port  <= rom_data[2:0];
                            r_valid <= 1'b1;
                            r_pc    <= w_pc_inc;
                            if (w_rom_op == OP_JMP) r_state <= ST_JTGT;
                        end
                    end
                    ST_JTGT: begin
                        r_pc    <= rom_data[ADDR_W-1:0];
                        r_state <= ST_RUN;
                    end
                    default: begin
                        r_pc    <= w_pc_inc;
                        r_state <= ST_RUN;
                    end
                endcase
            end
        end
    end

    assign rom_addr       = r_pc;
    assign lu_instruction = r_op;
    assign io_chip        = r_chip;
    assign io_port        = r_port;
    assign instr_valid    = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_mc14500_sequencer.sv
// ============================================================================
// Module   : tb_mc14500_sequencer
// Purpose  : Directed bench for mc14500_sequencer against a behavioural ROM.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mc14500_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       run = 1'b0;
    logic [6:0] rom_addr;
    logic [7:0] rom_data;
    logic       lu_result = 1'b1;
    logic [3:0] lu_instruction;
    logic       io_chip;
    logic [2:0] io_port;
    logic       instr_valid;
    logic       stk_ovf;
    logic       stk_unf;

    logic [7:0] rom [128];
    int         n_checks = 0;
    int         n_errors = 0;

    always #5 clk = ~clk;
    assign rom_data = rom[rom_addr];

    mc14500_sequencer #(
        .ADDR_W      (7),
        .STACK_DEPTH (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .run            (run),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .lu_result      (lu_result),
        .lu_instruction (lu_instruction),
        .io_chip        (io_chip),
        .io_port        (io_port),
        .instr_valid    (instr_valid),
        .stk_ovf        (stk_ovf),
        .stk_unf        (stk_unf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic [3:0] op, input logic v, input logic [6:0] a);
        @(posedge clk);
        #1;
        check({tag, ".op"},    lu_instruction, op);
        check({tag, ".valid"}, instr_valid, v);
        check({tag, ".addr"},  rom_addr, a);
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        run       = 1'b1;
        lu_result = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst.op",    lu_instruction, 4'h0);
        check("rst.valid", instr_valid, 1'b0);
        check("rst.addr",  rom_addr, 7'h00);
        check("rst.chip",  io_chip, 1'b0);
        check("rst.port",  io_port, 3'd0);
        check("rst.ovf",   stk_ovf, 1'b0);
        check("rst.unf",   stk_unf, 1'b0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) rom[i] = 8'h00;
        // Test A: sequential issue, SKZ, SKZ over JMP, JMP, run freeze in JTGT, RTN
        rom[8'h00] = 8'h15; rom[8'h01] = 8'h2A; rom[8'h02] = 8'hE0; rom[8'h03] = 8'h37;
        rom[8'h04] = 8'hE0; rom[8'h05] = 8'h36; rom[8'h06] = 8'hE0; rom[8'h07] = 8'hC0;
        rom[8'h08] = 8'h20; rom[8'h09] = 8'h44; rom[8'h0A] = 8'hC0; rom[8'h0B] = 8'h10;
        rom[8'h0C] = 8'h10; rom[8'h10] = 8'hC0; rom[8'h11] = 8'h40; rom[8'h12] = 8'hD0;
        rom[8'h40] = 8'hD0; rom[8'h41] = 8'h77; rom[8'h42] = 8'h81;
        do_reset();
        step("A1", 4'h0, 1'b0, 7'h00);
        step("A2", 4'h1, 1'b1, 7'h01);
        check("A2.chip", io_chip, 1'b0);
        check("A2.port", io_port, 3'd5);
        step("A3", 4'h2, 1'b1, 7'h02);
        check("A3.chip", io_chip, 1'b1);
        check("A3.port", io_port, 3'd2);
        step("A4", 4'hE, 1'b1, 7'h03);
        lu_result = 1'b0;
        step("A5", 4'h0, 1'b0, 7'h04);
        lu_result = 1'b1;
        step("A6", 4'hE, 1'b1, 7'h05);
        step("A7", 4'h3, 1'b1, 7'h06);
        check("A7.port", io_port, 3'd6);
        step("A8", 4'hE, 1'b1, 7'h07);
        lu_result = 1'b0;
        step("A9", 4'h0, 1'b0, 7'h08);
        lu_result = 1'b1;
        step("A10", 4'h0, 1'b0, 7'h09);
        step("A11", 4'h4, 1'b1, 7'h0A);
        step("A12", 4'hC, 1'b1, 7'h0B);
        step("A13", 4'h0, 1'b0, 7'h10);
        step("A14", 4'hC, 1'b1, 7'h11);
        run = 1'b0;
        step("A15", 4'h0, 1'b0, 7'h11);
        step("A16", 4'h0, 1'b0, 7'h11);
        step("A17", 4'h0, 1'b0, 7'h11);
        run = 1'b1;
        step("A18", 4'h0, 1'b0, 7'h40);
        step("A19", 4'hD, 1'b1, 7'h41);
`ifdef MC14500_RTN_STACK_EN
        step("A20", 4'h0, 1'b0, 7'h12);
        step("A21", 4'hD, 1'b1, 7'h13);
        step("A22", 4'h0, 1'b0, 7'h0C);
        step("A23", 4'h1, 1'b1, 7'h0D);
`else
        step("A20", 4'h0, 1'b0, 7'h42);
        step("A21", 4'h8, 1'b1, 7'h43);
        check("A21.port", io_port, 3'd1);
`endif
        check("A.unf", stk_unf, 1'b0);

        // Test B: RTN directly followed by a JMP word
        rom[8'h00] = 8'hD0; rom[8'h01] = 8'hC0; rom[8'h02] = 8'h33; rom[8'h03] = 8'h15;
        do_reset();
        step("B1", 4'h0, 1'b0, 7'h00);
        step("B2", 4'hD, 1'b1, 7'h01);
`ifdef MC14500_RTN_STACK_EN
        step("B3", 4'h0, 1'b0, 7'h02);
        check("B3.unf", stk_unf, 1'b1);
        step("B4", 4'h3, 1'b1, 7'h03);
`else
        step("B3", 4'h0, 1'b0, 7'h02);
        step("B4", 4'h0, 1'b0, 7'h03);
        step("B5", 4'h1, 1'b1, 7'h04);
        check("B5.unf", stk_unf, 1'b0);
`endif

        // Test C: PC wrap from the last address back to 0
        rom[8'h00] = 8'hC0; rom[8'h01] = 8'h7E; rom[8'h7E] = 8'h21; rom[8'h7F] = 8'h22;
        do_reset();
        step("C1", 4'h0, 1'b0, 7'h00);
        step("C2", 4'hC, 1'b1, 7'h01);
        step("C3", 4'h0, 1'b0, 7'h7E);
        step("C4", 4'h2, 1'b1, 7'h7F);
        check("C4.port", io_port, 3'd1);
        step("C5", 4'h2, 1'b1, 7'h00);
        check("C5.port", io_port, 3'd2);
        step("C6", 4'hC, 1'b1, 7'h01);

`ifdef MC14500_RTN_STACK_EN
        // Test D: five nested JMPs overflow a 4-deep stack, then unwind past empty
        rom[8'h01] = 8'h60;
        rom[8'h60] = 8'hC0; rom[8'h61] = 8'h64; rom[8'h64] = 8'hC0; rom[8'h65] = 8'h68;
        rom[8'h68] = 8'hC0; rom[8'h69] = 8'h6C; rom[8'h6C] = 8'hC0; rom[8'h6D] = 8'h70;
        rom[8'h70] = 8'hD0; rom[8'h6E] = 8'hD0; rom[8'h6A] = 8'hD0; rom[8'h66] = 8'hD0;
        rom[8'h62] = 8'hD0;
        do_reset();
        step("D1", 4'h0, 1'b0, 7'h00);
        step("D2", 4'hC, 1'b1, 7'h01);
        step("D3", 4'h0, 1'b0, 7'h60);
        step("D4", 4'hC, 1'b1, 7'h61);
        step("D5", 4'h0, 1'b0, 7'h64);
        step("D6", 4'hC, 1'b1, 7'h65);
        step("D7", 4'h0, 1'b0, 7'h68);
        step("D8", 4'hC, 1'b1, 7'h69);
        step("D9", 4'h0, 1'b0, 7'h6C);
        check("D9.ovf", stk_ovf, 1'b0);
        step("D10", 4'hC, 1'b1, 7'h6D);
        step("D11", 4'h0, 1'b0, 7'h70);
        check("D11.ovf", stk_ovf, 1'b1);
        step("D12", 4'hD, 1'b1, 7'h71);
        step("D13", 4'h0, 1'b0, 7'h6E);
        step("D14", 4'hD, 1'b1, 7'h6F);
        step("D15", 4'h0, 1'b0, 7'h6A);
        step("D16", 4'hD, 1'b1, 7'h6B);
        step("D17", 4'h0, 1'b0, 7'h66);
        step("D18", 4'hD, 1'b1, 7'h67);
        step("D19", 4'h0, 1'b0, 7'h62);
        check("D19.unf", stk_unf, 1'b0);
        step("D20", 4'hD, 1'b1, 7'h63);
        step("D21", 4'h0, 1'b0, 7'h64);
        check("D21.unf", stk_unf, 1'b1);
`endif

        // Test E: asynchronous reset between clock edges
        #3;
        reset = 1'b0;
        #1;
        check("E.op",    lu_instruction, 4'h0);
        check("E.valid", instr_valid, 1'b0);
        check("E.addr",  rom_addr, 7'h00);
        check("E.ovf",   stk_ovf, 1'b0);
        check("E.unf",   stk_unf, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
